// File: rtl/apple2_slot_initiator.sv
// apple2_slot_initiator
// Apple II slot-bus master. Generates the motherboard-side bus timing
// (PHI1, A, nWE, D, nDEVSEL, nIOSEL, nIOSTRB) from C7M so a peripheral card
// can be driven exactly as a real machine would drive it. One 6502 access is
// issued per accepted command. Without a command, idle read cycles run
// continuously, so PHI1 never stops.
//
// Ports:
//   C7M, nRES                    7 MHz clock (rising edge), async active-low reset
//   cmd_valid/ready/we/addr/wdata single-entry command request
//   rsp_valid, rsp_rdata         one-C7M completion pulse plus read data (00 for writes)
//   PHI1, A, nWE                 bus clock phase, address, R/W (low = write)
//   D_out, D_oe, D_in            split data bus: driven value, driver enable, sampled value
//   nDEVSEL, nIOSEL, nIOSTRB     active-low slot selects
module apple2_slot_initiator #(
  parameter int          SLOT       = 4,
  parameter bit          STRETCH_EN = 1'b1,
  parameter logic [15:0] IDLE_ADDR  = 16'h0000
) (
  input  logic        C7M,
  input  logic        nRES,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        PHI1,
  output logic [15:0] A,
  output logic        nWE,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [7:0]  D_in,
  output logic        nDEVSEL,
  output logic        nIOSEL,
  output logic        nIOSTRB
);

  // PX is the extra PHI1-high state that only appears in a long cycle.
  typedef enum logic [2:0] {P0, P1, P2, P3, PX, P4, P5, P6} phase_t;

  phase_t      phase, phase_nxt;
  logic [6:0]  cnt;

  logic        pend_v, pend_we;
  logic [15:0] pend_addr;
  logic [7:0]  pend_wdata;

  logic        act_v, act_we, act_dev, act_io, act_strb;

  logic        cyc_end;
  logic        dec_dev, dec_io, dec_strb;
  logic        phi1_nxt, ndev_nxt, nio_nxt, nstrb_nxt, doe_nxt;

  assign cmd_ready = ~pend_v;
  assign cyc_end   = (phase == P6);

  // Decode is done on the command about to become active; the result is
  // held in act_* for the whole cycle.
  assign dec_dev  = (pend_addr[15:4]  == (12'hC08 + 12'(SLOT)));
  assign dec_io   = (pend_addr[15:8]  == {4'hC, 4'(SLOT)});
  assign dec_strb = (pend_addr[15:11] == 5'b11001);

  always_comb begin
    phase_nxt = P0;
    case (phase)
      P0:      phase_nxt = P1;
      P1:      phase_nxt = P2;
      P2:      phase_nxt = P3;
      P3:      phase_nxt = (STRETCH_EN && cnt == 7'd64) ? PX : P4;
      PX:      phase_nxt = P4;
      P4:      phase_nxt = P5;
      P5:      phase_nxt = P6;
      default: phase_nxt = P0;
    endcase

    // Every bus output is registered, so it is computed from the state
    // being entered. At the P6->P0 edge phase_nxt is P0, which forces all
    // selects and D_oe inactive before act_* changes.
    phi1_nxt  = !(phase_nxt inside {P4, P5, P6});
    ndev_nxt  = !(!phi1_nxt && act_v && act_dev);
    nio_nxt   = !(!phi1_nxt && act_v && act_io);
    nstrb_nxt = !(!phi1_nxt && act_v && act_strb);
    doe_nxt   = (phase_nxt inside {P5, P6}) && act_v && act_we;
  end

  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      phase      <= P0;
      cnt        <= 7'd0;
      pend_v     <= 1'b0;
      pend_we    <= 1'b0;
      pend_addr  <= 16'h0000;
      pend_wdata <= 8'h00;
      act_v      <= 1'b0;
      act_we     <= 1'b0;
      act_dev    <= 1'b0;
      act_io     <= 1'b0;
      act_strb   <= 1'b0;
      PHI1       <= 1'b1;
      A          <= 16'h0000;
      nWE        <= 1'b1;
      D_out      <= 8'h00;
      D_oe       <= 1'b0;
      nDEVSEL    <= 1'b1;
      nIOSEL     <= 1'b1;
      nIOSTRB    <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 8'h00;
    end else begin
      phase     <= phase_nxt;
      PHI1      <= phi1_nxt;
      nDEVSEL   <= ndev_nxt;
      nIOSEL    <= nio_nxt;
      nIOSTRB   <= nstrb_nxt;
      D_oe      <= doe_nxt;
      rsp_valid <= 1'b0;

      if (cyc_end) begin
        cnt <= (cnt == 7'd64) ? 7'd0 : cnt + 7'd1;

        // Close the finishing cycle: sample the bus and report.
        rsp_valid <= act_v;
        if (act_v) rsp_rdata <= act_we ? 8'h00 : D_in;

        // Open the next cycle: the pending command, or an idle read.
        act_v    <= pend_v;
        act_we   <= pend_v & pend_we;
        act_dev  <= pend_v & dec_dev;
        act_io   <= pend_v & dec_io;
        act_strb <= pend_v & dec_strb;
        A        <= pend_v ? pend_addr : IDLE_ADDR;
        nWE      <= ~(pend_v & pend_we);
        D_out    <= (pend_v & pend_we) ? pend_wdata : 8'h00;
      end

      // The pending slot is empty whenever cmd_ready is high, so accepting
      // and promoting can never coincide. A command accepted on the P6 edge
      // therefore waits for the next cycle boundary.
      if (cmd_valid && !pend_v) begin
        pend_v     <= 1'b1;
        pend_we    <= cmd_we;
        pend_addr  <= cmd_addr;
        pend_wdata <= cmd_wdata;
      end else if (cyc_end) begin
        pend_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apple2_slot_initiator.sv
module tb_apple2_slot_initiator;
  localparam int          SLOT      = 4;
  localparam logic [15:0] IDLE_ADDR = 16'h0000;

  logic        C7M = 1'b0, nRES = 1'b0;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [15:0] cmd_addr = 16'h0;
  logic [7:0]  cmd_wdata = 8'h0;
  logic        cmd_ready, rsp_valid, PHI1, nWE, D_oe, nDEVSEL, nIOSEL, nIOSTRB;
  logic [7:0]  rsp_rdata, D_out, D_in;
  logic [15:0] A;

  logic        cmd_ready_ns, rsp_valid_ns, PHI1_ns, nWE_ns, D_oe_ns;
  logic        nDEVSEL_ns, nIOSEL_ns, nIOSTRB_ns;
  logic [7:0]  rsp_rdata_ns, D_out_ns;
  logic [7:0]  D_in_ns = 8'h00;
  logic [15:0] A_ns;

  int tests = 0, fails = 0;

  // Card model: what the card under test returns for a given address.
  function automatic logic [7:0] dmodel(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction
  assign D_in = dmodel(A);

  function automatic bit in_dev(input logic [15:0] a);
    int lo = 'hC080 + 16 * SLOT;
    return int'(a) >= lo && int'(a) < lo + 16;
  endfunction
  function automatic bit in_io(input logic [15:0] a);
    int lo = 'hC000 + 256 * SLOT;
    return int'(a) >= lo && int'(a) < lo + 256;
  endfunction
  function automatic bit in_strb(input logic [15:0] a);
    return int'(a) >= 'hC800 && int'(a) <= 'hCFFF;
  endfunction

  apple2_slot_initiator #(.SLOT(SLOT), .STRETCH_EN(1'b1), .IDLE_ADDR(IDLE_ADDR)) dut (
    .C7M(C7M), .nRES(nRES), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .PHI1(PHI1), .A(A), .nWE(nWE),
    .D_out(D_out), .D_oe(D_oe), .D_in(D_in),
    .nDEVSEL(nDEVSEL), .nIOSEL(nIOSEL), .nIOSTRB(nIOSTRB));

  apple2_slot_initiator #(.SLOT(SLOT), .STRETCH_EN(1'b0), .IDLE_ADDR(IDLE_ADDR)) dut_ns (
    .C7M(C7M), .nRES(nRES), .cmd_valid(1'b0), .cmd_ready(cmd_ready_ns),
    .cmd_we(1'b0), .cmd_addr(16'h0000), .cmd_wdata(8'h00),
    .rsp_valid(rsp_valid_ns), .rsp_rdata(rsp_rdata_ns), .PHI1(PHI1_ns), .A(A_ns), .nWE(nWE_ns),
    .D_out(D_out_ns), .D_oe(D_oe_ns), .D_in(D_in_ns),
    .nDEVSEL(nDEVSEL_ns), .nIOSEL(nIOSEL_ns), .nIOSTRB(nIOSTRB_ns));

  always #5 C7M = ~C7M;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Posedges since reset release: the phase after edge e is "edge e".
  int edge_cnt = 0;
  always @(posedge C7M or negedge nRES)
    if (!nRES) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;

  typedef struct {
    int          acc_e;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } cmd_t;

  cmd_t acc_q[$];   // commands awaiting their bus cycle
  cmd_t rsp_q[$];   // commands awaiting their response
  int   rsp_edges[$];
  bit   mon_on = 0;

  // ---------------- bus-cycle monitor ----------------
  int   k, cyc_start, hi_n, dev_n, io_n, strb_n, oe_n, lo_idx;
  int   bad_a, bad_sel, bad_oe, bad_dout, long_seen;
  bit   fall_seen, cur_cmd;
  logic prev_phi, exp_nwe;
  logic [15:0] exp_a;
  cmd_t cur;

  task automatic close_cycle(input int e);
    bit lng = (k % 65) == 64;
    chk("cycle_len", e - cyc_start, lng ? 8 : 7);
    chk("phi1_high_len", hi_n, lng ? 5 : 4);
    chk("devsel_len", dev_n, (cur_cmd && in_dev(cur.addr)) ? 3 : 0);
    chk("iosel_len", io_n, (cur_cmd && in_io(cur.addr)) ? 3 : 0);
    chk("iostrb_len", strb_n, (cur_cmd && in_strb(cur.addr)) ? 3 : 0);
    chk("doe_len", oe_n, (cur_cmd && cur.we) ? 2 : 0);
    chk("addr_nwe_held", bad_a, 0);
    chk("select_during_phi1", bad_sel, 0);
    chk("doe_window", bad_oe, 0);
    chk("dout_value", bad_dout, 0);
    if (lng) long_seen++;
  endtask

  task automatic open_cycle(input int e);
    k++;
    cyc_start = e;
    hi_n = 0; dev_n = 0; io_n = 0; strb_n = 0; oe_n = 0; lo_idx = 0;
    bad_a = 0; bad_sel = 0; bad_oe = 0; bad_dout = 0;
    cur_cmd = (acc_q.size() > 0) && (acc_q[0].acc_e < e);
    if (cur_cmd) cur = acc_q.pop_front();
    exp_a   = cur_cmd ? cur.addr : IDLE_ADDR;
    exp_nwe = cur_cmd ? ~cur.we : 1'b1;
  endtask

  always @(negedge C7M) if (mon_on) begin
    if (PHI1 && !prev_phi) begin
      close_cycle(edge_cnt);
      open_cycle(edge_cnt);
    end
    if (!PHI1 && !fall_seen) begin
      fall_seen = 1;
      chk("first_phi1_fall_edge", edge_cnt, 4);
    end
    if (PHI1) hi_n++;
    if (A !== exp_a || nWE !== exp_nwe) bad_a++;
    if (!nDEVSEL) begin dev_n++;  if (PHI1) bad_sel++; end
    if (!nIOSEL)  begin io_n++;   if (PHI1) bad_sel++; end
    if (!nIOSTRB) begin strb_n++; if (PHI1) bad_sel++; end
    if (D_oe) begin
      oe_n++;
      if (PHI1 || lo_idx == 0) bad_oe++;
      if (D_out !== cur.wdata) bad_dout++;
    end
    if (!PHI1) lo_idx++;
    prev_phi = PHI1;
  end

  // ---------------- response monitor ----------------
  logic rv_prev = 1'b0, rphi_prev = 1'b1;
  always @(negedge C7M) if (mon_on) begin
    if (rsp_valid) begin
      cmd_t r;
      int   lat;
      chk("rsp_pulse_width", rv_prev, 0);
      chk("rsp_in_first_p0", {rphi_prev, PHI1}, 2'b01);
      chk("rsp_expected", rsp_q.size() > 0, 1);
      if (rsp_q.size() > 0) begin
        r = rsp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, r.we ? 8'h00 : dmodel(r.addr));
        lat = edge_cnt - r.acc_e;
        chk("rsp_latency_8_16", lat >= 8 && lat <= 16, 1);
        rsp_edges.push_back(edge_cnt);
      end
    end
    rv_prev   = rsp_valid;
    rphi_prev = PHI1;
  end

  // ---------------- no-stretch instance ----------------
  int   ns_start = 0;
  logic ns_prev = 1'b1;
  always @(negedge C7M) if (mon_on) begin
    if (PHI1_ns && !ns_prev) begin
      chk("nostretch_cycle_len", edge_cnt - ns_start, 7);
      ns_start = edge_cnt;
    end
    ns_prev = PHI1_ns;
  end

  // ---------------- driver ----------------
  task automatic issue(input logic we, input logic [15:0] addr, input logic [7:0] wd);
    cmd_t c;
    bit   ok = 0;
    @(negedge C7M);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd;
    for (int i = 0; i < 40; i++) begin
      if (cmd_ready) begin ok = 1; break; end
      @(negedge C7M);
    end
    if (!ok) begin
      chk("accept_timeout", cmd_ready, 1);
      cmd_valid = 1'b0;
      return;
    end
    c.acc_e = edge_cnt + 1; c.we = we; c.addr = addr; c.wdata = wd;
    @(posedge C7M);
    acc_q.push_back(c);
    rsp_q.push_back(c);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && rsp_q.size() != 0; i++) @(negedge C7M);
    chk(name, rsp_q.size(), 0);
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 16'(32'hC080 + 16 * SLOT + $urandom_range(0, 15));
      1:       return 16'(32'hC000 + 256 * SLOT + $urandom_range(0, 255));
      2:       return 16'(32'hC800 + $urandom_range(0, 2047));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rv_seen;
    nRES = 1'b0;
    repeat (3) @(posedge C7M);
    @(negedge C7M);
    chk("rst_PHI1", PHI1, 1);       chk("rst_A", A, 16'h0000);
    chk("rst_nWE", nWE, 1);         chk("rst_D_out", D_out, 8'h00);
    chk("rst_D_oe", D_oe, 0);       chk("rst_nDEVSEL", nDEVSEL, 1);
    chk("rst_nIOSEL", nIOSEL, 1);   chk("rst_nIOSTRB", nIOSTRB, 1);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 8'h00);

    // Cycle 0 starts in the P0 held during reset (PHI1 high, idle, A=0).
    k = 0; cyc_start = 0; hi_n = 1; dev_n = 0; io_n = 0; strb_n = 0; oe_n = 0;
    lo_idx = 0; bad_a = 0; bad_sel = 0; bad_oe = 0; bad_dout = 0; long_seen = 0;
    fall_seen = 0; cur_cmd = 0; prev_phi = 1'b1; exp_a = 16'h0000; exp_nwe = 1'b1;
    cur = '{0, 1'b0, 16'h0, 8'h0};
    #1 mon_on = 1; nRES = 1'b1;

    // Directed decode cases
    issue(1'b1, 16'hC0C0, 8'h12);
    issue(1'b0, 16'hC400, 8'h00);
    issue(1'b0, 16'hCFFF, 8'h00);
    issue(1'b0, 16'hC0D0, 8'h00);
    drain("drain_directed");

    // Back-to-back write then read: consecutive cycles, responses 7 apart
    issue(1'b1, 16'hC0C3, 8'h5A);
    issue(1'b0, 16'hC0C3, 8'h00);
    drain("drain_b2b");
    n = rsp_edges.size();
    chk("b2b_rsp_count", n >= 2, 1);
    if (n >= 2) chk("b2b_rsp_spacing", rsp_edges[n-1] - rsp_edges[n-2], 7);

    // Randomised traffic, long enough to cross several stretched cycles
    for (int i = 0; i < 120; i++) begin
      int gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
      repeat (gap) @(negedge C7M);
      issue(1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
    end
    drain("drain_random");
    chk("stretch_seen", long_seen > 0, 1);

    // Reset in the middle of a write cycle
    mon_on = 0;
    @(negedge C7M);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 16'hC0C0; cmd_wdata = 8'h99;
    for (int i = 0; i < 40 && !cmd_ready; i++) @(negedge C7M);
    @(posedge C7M);
    #1 cmd_valid = 1'b0;
    for (int i = 0; i < 40 && !D_oe; i++) @(negedge C7M);
    chk("mid_reached_p5", D_oe, 1);
    #1 nRES = 1'b0;
    #1;
    chk("mid_D_oe", D_oe, 0);       chk("mid_nDEVSEL", nDEVSEL, 1);
    chk("mid_nIOSEL", nIOSEL, 1);   chk("mid_nIOSTRB", nIOSTRB, 1);
    chk("mid_PHI1", PHI1, 1);       chk("mid_cmd_ready", cmd_ready, 1);
    repeat (3) @(posedge C7M);
    @(negedge C7M);
    #1 nRES = 1'b1;
    rv_seen = 0;
    repeat (30) begin
      @(negedge C7M);
      if (rsp_valid) rv_seen++;
    end
    chk("no_rsp_after_abort", rv_seen, 0);
    chk("ready_after_release", cmd_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
